// File: rtl/bsg_manycore_request_initiator.sv
// rtl/bsg_manycore_request_initiator.sv - credit-metered request initiator with in-order response FIFO
// Optional fence support: define BSG_MANYCORE_INITIATOR_FENCE_EN to add fence_i / fence_done_o.
module bsg_manycore_request_initiator #(
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 28,
    parameter int max_out_credits_p = 16,
    localparam int credit_w_lp            = $clog2(max_out_credits_p + 1),
    localparam int packet_width_lp        = addr_width_p + data_width_p + 4 + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int return_packet_width_lp = data_width_p + 2 + x_cord_width_p + y_cord_width_p,
    localparam int link_sif_width_lp      = packet_width_lp + return_packet_width_lp + 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [link_sif_width_lp-1:0]      link_sif_i,
    output logic [link_sif_width_lp-1:0]      link_sif_o,
    input  logic [packet_width_lp-1:0]        req_packet_i,
    input  logic                              req_v_i,
    output logic                              req_ready_o,
`ifdef BSG_MANYCORE_INITIATOR_FENCE_EN
    input  logic                              fence_i,
    output logic                              fence_done_o,
`endif
    output logic [return_packet_width_lp-1:0] resp_packet_o,
    output logic                              resp_v_o,
    input  logic                              resp_yumi_i,
    output logic [credit_w_lp-1:0]            out_credits_o,
    output logic                              idle_o
);

    localparam int ptr_w_lp = (max_out_credits_p > 1) ? $clog2(max_out_credits_p) : 1;
    localparam logic [credit_w_lp-1:0] max_credits_lp = credit_w_lp'(max_out_credits_p);

    // link_sif = {fwd.v, fwd.data, fwd.ready_and_rev, rev.v, rev.data, rev.ready_and_rev}
    logic                              fwd_v_in;
    logic                              fwd_ready_in;
    logic                              rev_v_in;
    logic [return_packet_width_lp-1:0] rev_data_in;
    logic                              unused_link_bits;

    assign rev_data_in  = link_sif_i[return_packet_width_lp:1];
    assign rev_v_in     = link_sif_i[return_packet_width_lp+1];
    assign fwd_ready_in = link_sif_i[return_packet_width_lp+2];
    assign fwd_v_in     = link_sif_i[link_sif_width_lp-1];
    assign unused_link_bits = ^{fwd_v_in, link_sif_i[link_sif_width_lp-2:return_packet_width_lp+3], link_sif_i[0]};

    logic [credit_w_lp-1:0]            credits_q, credits_d;
    logic [credit_w_lp-1:0]            count_q, count_d;
    logic [ptr_w_lp-1:0]               rd_ptr_q, wr_ptr_q;
    logic [return_packet_width_lp-1:0] mem_q [max_out_credits_p];
    logic                              have_credit;
    logic                              fence_block;
    logic                              fwd_v_out;
    logic                              issue;
    logic                              enq;
    logic                              deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(max_out_credits_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign have_credit = (credits_q != '0);
    // fwd.v is also held low while fencing so the router never takes an uncounted packet
    assign fwd_v_out   = req_v_i & have_credit & ~fence_block & ~reset_i;
    assign req_ready_o = fwd_ready_in & have_credit & ~fence_block & ~reset_i;
    assign issue       = req_v_i & req_ready_o;

    assign resp_v_o      = (count_q != '0) & ~reset_i;
    assign resp_packet_o = mem_q[rd_ptr_q];
    assign deq           = resp_yumi_i & resp_v_o;
    assign enq           = rev_v_in & ~reset_i;

    assign credits_d = credits_q - credit_w_lp'(issue) + credit_w_lp'(deq);
    assign count_d   = count_q + credit_w_lp'(enq) - credit_w_lp'(deq);

    assign out_credits_o = credits_q;
    assign idle_o        = (credits_q == max_credits_lp) & ~resp_v_o;

    assign link_sif_o = {fwd_v_out, req_packet_i, 1'b0, 1'b0, {return_packet_width_lp{1'b0}}, 1'b1};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits_q <= max_credits_lp;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= rev_data_in;
    end

`ifdef BSG_MANYCORE_INITIATOR_FENCE_EN
    typedef enum logic {RUN_S, FENCE_S} fence_state_e;
    fence_state_e state_q;
    logic         fence_done_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= RUN_S;
            fence_done_q <= 1'b0;
        end else begin
            fence_done_q <= 1'b0;
            case (state_q)
                RUN_S: begin
                    // Already drained: acknowledge at once without entering FENCE
                    if (fence_i) begin
                        if ((credits_q == max_credits_lp) && !issue) fence_done_q <= 1'b1;
                        else                                          state_q      <= FENCE_S;
                    end
                end
                FENCE_S: begin
                    if (credits_q == max_credits_lp) begin
                        state_q      <= RUN_S;
                        fence_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN_S;
            endcase
        end
    end

    assign fence_block  = (state_q == FENCE_S);
    assign fence_done_o = fence_done_q;
`else
    assign fence_block = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!fwd_v_in);
            assert (!(rev_v_in && (count_q == max_credits_lp) && !deq));
            assert (!(resp_yumi_i && !resp_v_o));
            assert (credits_q <= max_credits_lp);
            assert (!((credits_q == max_credits_lp) && deq && !issue));
            assert (!((credits_q == '0) && issue));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_request_initiator.sv
// tb/tb_bsg_manycore_request_initiator.sv - directed self-checking bench for bsg_manycore_request_initiator
module tb_bsg_manycore_request_initiator;

    localparam int x_w     = 7;
    localparam int y_w     = 7;
    localparam int d_w     = 32;
    localparam int a_w     = 28;
    localparam int credits = 4;
    localparam int pkt_w   = a_w + d_w + 4 + 2 * (x_w + y_w);
    localparam int ret_w   = d_w + 2 + x_w + y_w;
    localparam int link_w  = pkt_w + ret_w + 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [link_w-1:0] link_in;
    logic [link_w-1:0] link_out;
    logic [pkt_w-1:0]  req_packet = '0;
    logic              req_v = 1'b0;
    logic              req_ready;
    logic [ret_w-1:0]  resp_packet;
    logic              resp_v;
    logic              resp_yumi = 1'b0;
    logic [2:0]        out_credits;
    logic              idle;
    logic              fwd_ready_in = 1'b0;
    logic              rev_v_in = 1'b0;
    logic [ret_w-1:0]  rev_data_in = '0;
`ifdef BSG_MANYCORE_INITIATOR_FENCE_EN
    logic              fence = 1'b0;
    logic              fence_done;
`endif

    logic              fwd_v_out;
    logic [pkt_w-1:0]  fwd_data_out;
    logic              fwd_ready_out;
    logic              rev_v_out;
    logic [ret_w-1:0]  rev_data_out;
    logic              rev_ready_out;

    assign link_in       = {1'b0, {pkt_w{1'b0}}, fwd_ready_in, rev_v_in, rev_data_in, 1'b0};
    assign fwd_v_out     = link_out[link_w-1];
    assign fwd_data_out  = link_out[link_w-2:ret_w+3];
    assign fwd_ready_out = link_out[ret_w+2];
    assign rev_v_out     = link_out[ret_w+1];
    assign rev_data_out  = link_out[ret_w:1];
    assign rev_ready_out = link_out[0];

    int pass_cnt = 0;
    int total_cnt = 0;

    bsg_manycore_request_initiator #(
        .x_cord_width_p    (x_w),
        .y_cord_width_p    (y_w),
        .data_width_p      (d_w),
        .addr_width_p      (a_w),
        .max_out_credits_p (credits)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .link_sif_i    (link_in),
        .link_sif_o    (link_out),
        .req_packet_i  (req_packet),
        .req_v_i       (req_v),
        .req_ready_o   (req_ready),
`ifdef BSG_MANYCORE_INITIATOR_FENCE_EN
        .fence_i       (fence),
        .fence_done_o  (fence_done),
`endif
        .resp_packet_o (resp_packet),
        .resp_v_o      (resp_v),
        .resp_yumi_i   (resp_yumi),
        .out_credits_o (out_credits),
        .idle_o        (idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic return_and_drain(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            rev_v_in    = 1'b1;
            rev_data_in = ret_w'(i);
            resp_yumi   = resp_v;
            step();
        end
        rev_v_in = 1'b0;
        guard    = 0;
        while (resp_v && guard < 20) begin
            resp_yumi = 1'b1;
            step();
            guard++;
        end
        resp_yumi = 1'b0;
        #1;
        total_cnt++;
        if (out_credits !== 3'd4 || resp_v !== 1'b0)
            $display("FAIL drain_idle: credits=%0d resp_v=%b expected credits=4 resp_v=0", out_credits, resp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        fwd_ready_in = 1'b1;
        req_v        = 1'b1;
        #2 reset = 1'b1;
        step();
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else pass_cnt++;
        total_cnt++; if (fwd_v_out !== 1'b0) $display("FAIL reset_fwd_v: got %b expected 0", fwd_v_out); else pass_cnt++;
        total_cnt++; if (resp_v !== 1'b0) $display("FAIL reset_resp_v: got %b expected 0", resp_v); else pass_cnt++;
        req_v = 1'b0;
        step();
        reset = 1'b0;
        #1;
        total_cnt++; if (out_credits !== 3'd4) $display("FAIL idle_credits: got %0d expected 4", out_credits); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("FAIL idle_flag: got %b expected 1", idle); else pass_cnt++;
        total_cnt++; if (rev_ready_out !== 1'b1) $display("FAIL idle_rev_ready: got %b expected 1", rev_ready_out); else pass_cnt++;
        total_cnt++; if (fwd_ready_out !== 1'b0 || rev_v_out !== 1'b0 || rev_data_out !== '0)
            $display("FAIL idle_incoming_closed: fwd_ready=%b rev_v=%b rev_data=%h expected 0/0/0", fwd_ready_out, rev_v_out, rev_data_out);
        else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b expected 1", req_ready); else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        int issued;
        int fwd_v_seen;
        fwd_ready_in = 1'b0;
        req_v        = 1'b1;
        issued       = 0;
        fwd_v_seen   = 0;
        for (int i = 0; i < 5; i++) begin
            req_packet = pkt_w'(i + 1);
            #1;
            if (req_v && req_ready) issued++;
            if (fwd_v_out) fwd_v_seen++;
            step();
        end
        total_cnt++; if (issued !== 0 || out_credits !== 3'd4) $display("FAIL bp_no_issue: issued=%0d credits=%0d expected 0/4", issued, out_credits); else pass_cnt++;
        total_cnt++; if (fwd_v_seen !== 5) $display("FAIL bp_fwd_v_held: got %0d expected 5", fwd_v_seen); else pass_cnt++;
        fwd_ready_in = 1'b1;
        issued       = 0;
        for (int i = 0; i < 5; i++) begin
            req_packet = pkt_w'(16 + i);
            #1;
            if (i == 0) begin
                total_cnt++; if (fwd_data_out !== pkt_w'(16)) $display("FAIL bp_fwd_data: got %h expected %h", fwd_data_out, pkt_w'(16)); else pass_cnt++;
            end
            if (i == 4) begin
                total_cnt++; if (req_ready !== 1'b0 || fwd_v_out !== 1'b0) $display("FAIL bp_fifth_blocked: ready=%b fwd_v=%b expected 0/0", req_ready, fwd_v_out); else pass_cnt++;
            end
            if (req_ready) issued++;
            step();
        end
        total_cnt++; if (issued !== 4 || out_credits !== 3'd0) $display("FAIL bp_four_issues: issued=%0d credits=%0d expected 4/0", issued, out_credits); else pass_cnt++;
        rev_v_in    = 1'b1;
        rev_data_in = ret_w'('hB0);
        #1;
        total_cnt++; if (resp_v !== 1'b0) $display("FAIL resp_latency_early: got %b expected 0", resp_v); else pass_cnt++;
        step();
        rev_v_in  = 1'b0;
        resp_yumi = 1'b1;
        #1;
        total_cnt++; if (resp_v !== 1'b1 || req_ready !== 1'b0) $display("FAIL yumi_no_bypass: resp_v=%b ready=%b expected 1/0", resp_v, req_ready); else pass_cnt++;
        step();
        resp_yumi = 1'b0;
        #1;
        total_cnt++; if (out_credits !== 3'd1 || req_ready !== 1'b1) $display("FAIL yumi_restores: credits=%0d ready=%b expected 1/1", out_credits, req_ready); else pass_cnt++;
        step();
        req_v = 1'b0;
        #1;
        total_cnt++; if (out_credits !== 3'd0) $display("FAIL fifth_issued: credits=%0d expected 0", out_credits); else pass_cnt++;
        return_and_drain(4);
    endtask

    task automatic test_same_cycle();
        req_v = 1'b1;
        step();
        step();
        req_v = 1'b0;
        #1;
        total_cnt++; if (out_credits !== 3'd2) $display("FAIL sc_setup_credits: got %0d expected 2", out_credits); else pass_cnt++;
        rev_v_in    = 1'b1;
        rev_data_in = ret_w'('hD0);
        step();
        rev_v_in  = 1'b0;
        req_v     = 1'b1;
        resp_yumi = 1'b1;
        #1;
        total_cnt++; if (resp_v !== 1'b1 || req_ready !== 1'b1) $display("FAIL sc_both_active: resp_v=%b ready=%b expected 1/1", resp_v, req_ready); else pass_cnt++;
        step();
        req_v     = 1'b0;
        resp_yumi = 1'b0;
        #1;
        total_cnt++; if (out_credits !== 3'd2) $display("FAIL sc_credits_hold: got %0d expected 2", out_credits); else pass_cnt++;
        total_cnt++; if (resp_v !== 1'b0) $display("FAIL sc_fifo_drop: resp_v=%b expected 0", resp_v); else pass_cnt++;
        return_and_drain(2);
    endtask

    task automatic test_ordering();
        logic [ret_w-1:0] exp_data;
        req_v = 1'b1;
        repeat (4) step();
        req_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rev_v_in    = 1'b1;
            rev_data_in = ret_w'(8'hA0 + i);
            step();
            if (i == 0) begin
                #1;
                total_cnt++; if (resp_v !== 1'b1 || resp_packet !== ret_w'('hA0)) $display("FAIL ord_first_latency: resp_v=%b data=%h expected 1/a0", resp_v, resp_packet); else pass_cnt++;
            end
        end
        rev_v_in = 1'b0;
        repeat (20) step();
        total_cnt++; if (resp_v !== 1'b1 || resp_packet !== ret_w'('hA0) || out_credits !== 3'd0)
            $display("FAIL ord_stall: resp_v=%b data=%h credits=%0d expected 1/a0/0", resp_v, resp_packet, out_credits);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_data  = ret_w'(8'hA0 + i);
            resp_yumi = 1'b1;
            #1;
            total_cnt++; if (resp_v !== 1'b1 || resp_packet !== exp_data) $display("FAIL ord_data_%0d: resp_v=%b data=%h expected 1/%h", i, resp_v, resp_packet, exp_data); else pass_cnt++;
            step();
        end
        resp_yumi = 1'b0;
        #1;
        total_cnt++; if (resp_v !== 1'b0 || out_credits !== 3'd4 || idle !== 1'b1)
            $display("FAIL ord_done: resp_v=%b credits=%0d idle=%b expected 0/4/1", resp_v, out_credits, idle);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req_v = 1'b1;
        repeat (3) step();
        req_v       = 1'b0;
        rev_v_in    = 1'b1;
        rev_data_in = ret_w'('hC0);
        step();
        rev_v_in = 1'b0;
        #1;
        total_cnt++; if (resp_v !== 1'b1 || out_credits !== 3'd1) $display("FAIL rm_setup: resp_v=%b credits=%0d expected 1/1", resp_v, out_credits); else pass_cnt++;
        req_v = 1'b1;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (resp_v !== 1'b0 || out_credits !== 3'd4) $display("FAIL rm_async_clear: resp_v=%b credits=%0d expected 0/4", resp_v, out_credits); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0 || fwd_v_out !== 1'b0) $display("FAIL rm_async_outputs: ready=%b fwd_v=%b expected 0/0", req_ready, fwd_v_out); else pass_cnt++;
        step();
        req_v = 1'b0;
        reset = 1'b0;
        #1;
        total_cnt++; if (out_credits !== 3'd4 || idle !== 1'b1 || resp_v !== 1'b0)
            $display("FAIL rm_release: credits=%0d idle=%b resp_v=%b expected 4/1/0", out_credits, idle, resp_v);
        else pass_cnt++;
        step();
    endtask

`ifdef BSG_MANYCORE_INITIATOR_FENCE_EN
    task automatic test_fence();
        int done_cnt;
        int done_cycle;
        int ready_cycle;
        int yumis;
        fence = 1'b1;
        step();
        fence = 1'b0;
        #1;
        total_cnt++; if (fence_done !== 1'b1) $display("FAIL fence_full_pulse: got %b expected 1", fence_done); else pass_cnt++;
        step();
        total_cnt++; if (fence_done !== 1'b0 || req_ready !== 1'b1) $display("FAIL fence_full_after: done=%b ready=%b expected 0/1", fence_done, req_ready); else pass_cnt++;
        req_v = 1'b1;
        repeat (3) step();
        req_v = 1'b0;
        fence = 1'b1;
        step();
        fence = 1'b0;
        #1;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL fence_blocks: ready=%b expected 0", req_ready); else pass_cnt++;
        done_cnt    = 0;
        done_cycle  = -1;
        ready_cycle = -1;
        yumis       = 0;
        for (int c = 0; c < 12; c++) begin
            rev_v_in    = (c < 3);
            rev_data_in = ret_w'(c);
            resp_yumi   = resp_v;
            if (resp_v) yumis++;
            #1;
            if (fence_done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (req_ready && ready_cycle < 0) ready_cycle = c;
            step();
        end
        rev_v_in  = 1'b0;
        resp_yumi = 1'b0;
        total_cnt++; if (done_cnt !== 1 || done_cycle !== 5) $display("FAIL fence_done_pulse: count=%0d cycle=%0d expected 1/5", done_cnt, done_cycle); else pass_cnt++;
        total_cnt++; if (ready_cycle !== 5 || yumis !== 3) $display("FAIL fence_resume: ready_cycle=%0d yumis=%0d expected 5/3", ready_cycle, yumis); else pass_cnt++;
        req_v = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL fence_issue_after: ready=%b expected 1", req_ready); else pass_cnt++;
        step();
        req_v = 1'b0;
        return_and_drain(1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_backpressure();
        test_same_cycle();
        test_ordering();
        test_reset_mid();
`ifdef BSG_MANYCORE_INITIATOR_FENCE_EN
        test_fence();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
